// File: rtl/pc_seq_ctl.sv
// pc_seq_ctl: front-end sequencer for pc_gen and reg_array.
// Arbitrates between reset hold-off, pipeline stalls, interrupt entry and
// normal flow; owns the saved return PC and the in-service flag.

`ifndef PC_IGN
`define PC_IGN 4'd0
`endif
`ifndef PC_KEP
`define PC_KEP 4'd1
`endif
`ifndef PC_IRQ
`define PC_IRQ 4'd2
`endif
`ifndef PC_RST
`define PC_RST 4'd3
`endif

module pc_seq_ctl #(
  parameter int RST_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        irq_req,
  input  logic        irq_en,
  input  logic        branch_slot,
  input  logic        ret_req,
  input  logic [31:0] pc_i,
  output logic [3:0]  pc_prectl,
  output logic        rd_clk_cls,
  output logic [31:0] zz_spc,
  output logic        irq_ack,
  output logic        id_flush,
  output logic        in_svc
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_IRQ   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] RST_LOAD   = 8'(RST_CYCLES);
  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] spc_reg, spc_next;
  logic        svc_reg, svc_next;
  logic        take;

  // Interrupt entry is only allowed on a quiet, non-delay-slot RUN cycle,
  // so the saved PC always names a restartable instruction.
  assign take = irq_req & irq_en & ~svc_reg & ~branch_slot & ~stall_req & ~ret_req;

  // State, counter, saved PC and in-service flag; rst dominates everything.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg <= ST_RESET;
      cnt_reg   <= RST_LOAD;
      spc_reg   <= 32'd0;
      svc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      spc_reg   <= spc_next;
      svc_reg   <= svc_next;
    end
  end

  // Next-state logic. The reset counter runs down to zero (one RESET cycle
  // per count after rst drops); the flush counter leaves on its last count
  // so FLUSH lasts exactly FLUSH_CYCLES non-stalled cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    spc_next   = spc_reg;
    svc_next   = svc_reg;
    case (state_reg)
      ST_RESET: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      ST_RUN: begin
        if (take) begin
          spc_next   = pc_i;
          svc_next   = 1'b1;
          state_next = ST_IRQ;
        end else if (ret_req && svc_reg) begin
          svc_next = 1'b0;
        end
      end
      ST_IRQ: begin
        state_next = ST_FLUSH;
        cnt_next   = FLUSH_LOAD;
      end
      ST_FLUSH: begin
        if (!stall_req) begin
          if (cnt_reg <= 8'd1) begin
            cnt_next   = 8'd0;
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
      end
      default: begin
        state_next = ST_RESET;
        cnt_next   = RST_LOAD;
      end
    endcase
  end

  // Output decode: only state and the live stall request, so stalls
  // take effect in the same cycle they are raised.
  always_comb begin
    pc_prectl  = `PC_IGN;
    rd_clk_cls = 1'b0;
    id_flush   = 1'b0;
    irq_ack    = 1'b0;
    case (state_reg)
      ST_RESET: begin
        pc_prectl  = `PC_RST;
        rd_clk_cls = 1'b1;
        id_flush   = 1'b1;
      end
      ST_RUN: begin
        pc_prectl  = stall_req ? `PC_KEP : `PC_IGN;
        rd_clk_cls = stall_req;
      end
      ST_IRQ: begin
        // The flush cancels the stalled instruction, so stall is ignored here.
        pc_prectl = `PC_IRQ;
        irq_ack   = 1'b1;
        id_flush  = 1'b1;
      end
      ST_FLUSH: begin
        pc_prectl  = stall_req ? `PC_KEP : `PC_IGN;
        rd_clk_cls = stall_req;
        id_flush   = 1'b1;
      end
      default: begin
        pc_prectl  = `PC_RST;
        rd_clk_cls = 1'b1;
        id_flush   = 1'b1;
      end
    endcase
  end

  assign zz_spc = spc_reg;
  assign in_svc = svc_reg;

endmodule

// File: tb/tb_pc_seq_ctl.sv
// tb_pc_seq_ctl: cycle-by-cycle vector table for pc_seq_ctl plus hand
// sequences for reset-during-IRQ and the reset hold-off length.

module tb_pc_seq_ctl;

  localparam logic [3:0] E_IGN = 4'd0;
  localparam logic [3:0] E_KEP = 4'd1;
  localparam logic [3:0] E_IRQ = 4'd2;
  localparam logic [3:0] E_RST = 4'd3;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        stall_req = 1'b0;
  logic        irq_req = 1'b0;
  logic        irq_en = 1'b0;
  logic        branch_slot = 1'b0;
  logic        ret_req = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic [3:0]  pc_prectl;
  logic        rd_clk_cls;
  logic [31:0] zz_spc;
  logic        irq_ack;
  logic        id_flush;
  logic        in_svc;

  int tests = 0;
  int fails = 0;

  pc_seq_ctl #(.RST_CYCLES(4), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .rst(rst), .stall_req(stall_req), .irq_req(irq_req),
    .irq_en(irq_en), .branch_slot(branch_slot), .ret_req(ret_req), .pc_i(pc_i),
    .pc_prectl(pc_prectl), .rd_clk_cls(rd_clk_cls), .zz_spc(zz_spc),
    .irq_ack(irq_ack), .id_flush(id_flush), .in_svc(in_svc)
  );

  always #5 clock = ~clock;

  // Inputs of one cycle and the outputs expected during that same cycle.
  typedef struct packed {
    logic        rst, stall, irq, en, br, ret;
    logic [31:0] pc;
    logic [3:0]  e_pc;
    logic        e_rd, e_fl, e_ack, e_svc;
    logic [31:0] e_spc;
  } vec_t;

  vec_t tv [64];
  int   nv = 0;

  task automatic add(input logic r, input logic s, input logic i, input logic e,
                     input logic b, input logic t, input logic [31:0] p,
                     input logic [3:0] epc, input logic erd, input logic efl,
                     input logic eack, input logic esvc, input logic [31:0] espc);
    tv[nv] = '{r, s, i, e, b, t, p, epc, erd, efl, eack, esvc, espc};
    nv++;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall_req = v.stall; irq_req = v.irq; irq_en = v.en;
    branch_slot = v.br; ret_req = v.ret; pc_i = v.pc;
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("pc_prectl", idx, {28'd0, pc_prectl}, {28'd0, v.e_pc});
    chk("rd_clk_cls", idx, {31'd0, rd_clk_cls}, {31'd0, v.e_rd});
    chk("id_flush", idx, {31'd0, id_flush}, {31'd0, v.e_fl});
    chk("irq_ack", idx, {31'd0, irq_ack}, {31'd0, v.e_ack});
    chk("in_svc", idx, {31'd0, in_svc}, {31'd0, v.e_svc});
    chk("zz_spc", idx, zz_spc, v.e_spc);
  endtask

  initial begin
    int rst_seen;
    //   rst stl irq en br ret pc          prectl rd fl ack svc spc
    add(1, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 0 reset values
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 1 first rst=0 edge
    add(0, 0, 1, 1, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 2 irq ignored in reset
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 3
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 4
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 5 last reset cycle
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_IGN, 0, 0, 0, 0, 32'h0);   // 6 RUN
    add(0, 1, 0, 0, 0, 0, 32'h0,   E_KEP, 1, 0, 0, 0, 32'h0);   // 7 stall x3
    add(0, 1, 0, 0, 0, 0, 32'h0,   E_KEP, 1, 0, 0, 0, 32'h0);   // 8
    add(0, 1, 0, 0, 0, 0, 32'h0,   E_KEP, 1, 0, 0, 0, 32'h0);   // 9
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_IGN, 0, 0, 0, 0, 32'h0);   // 10
    add(0, 0, 1, 1, 0, 0, 32'h40,  E_IGN, 0, 0, 0, 0, 32'h0);   // 11 take at 0x40
    add(0, 0, 1, 1, 0, 0, 32'h44,  E_IRQ, 0, 1, 1, 1, 32'h40);  // 12 IRQ
    add(0, 0, 1, 1, 0, 0, 32'h48,  E_IGN, 0, 1, 0, 1, 32'h40);  // 13 FLUSH
    add(0, 0, 1, 1, 0, 0, 32'h4c,  E_IGN, 0, 1, 0, 1, 32'h40);  // 14 FLUSH
    add(0, 0, 1, 1, 0, 0, 32'h80,  E_IGN, 0, 0, 0, 1, 32'h40);  // 15 no nesting
    add(0, 0, 1, 1, 0, 1, 32'h84,  E_IGN, 0, 0, 0, 1, 32'h40);  // 16 ret
    add(0, 0, 1, 1, 1, 0, 32'h100, E_IGN, 0, 0, 0, 0, 32'h40);  // 17 delay slot blocks
    add(0, 0, 1, 1, 0, 0, 32'h104, E_IGN, 0, 0, 0, 0, 32'h40);  // 18 take at 0x104
    add(0, 1, 0, 1, 0, 0, 32'h108, E_IRQ, 0, 1, 1, 1, 32'h104); // 19 IRQ ignores stall
    add(0, 1, 0, 1, 0, 0, 32'h108, E_KEP, 1, 1, 0, 1, 32'h104); // 20 FLUSH stalled
    add(0, 1, 0, 1, 0, 0, 32'h108, E_KEP, 1, 1, 0, 1, 32'h104); // 21 FLUSH stalled
    add(0, 0, 0, 1, 0, 0, 32'h108, E_IGN, 0, 1, 0, 1, 32'h104); // 22 FLUSH
    add(0, 0, 0, 1, 0, 1, 32'h10c, E_IGN, 0, 1, 0, 1, 32'h104); // 23 FLUSH, ret ignored
    add(0, 0, 0, 1, 0, 0, 32'h110, E_IGN, 0, 0, 0, 1, 32'h104); // 24 RUN, still in svc
    add(0, 0, 0, 1, 0, 1, 32'h114, E_IGN, 0, 0, 0, 1, 32'h104); // 25 ret
    add(0, 0, 1, 1, 0, 0, 32'h200, E_IGN, 0, 0, 0, 0, 32'h104); // 26 take at 0x200
    add(0, 0, 0, 1, 0, 0, 32'h204, E_IRQ, 0, 1, 1, 1, 32'h200); // 27 IRQ
    add(1, 0, 0, 1, 0, 0, 32'h208, E_IGN, 0, 1, 0, 1, 32'h200); // 28 rst in FLUSH
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 29 aborted
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 30
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 31
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 32
    add(0, 0, 0, 0, 0, 0, 32'h0,   E_RST, 1, 1, 0, 0, 32'h0);   // 33
    add(0, 0, 1, 0, 0, 0, 32'h300, E_IGN, 0, 0, 0, 0, 32'h0);   // 34 masked by irq_en
    add(0, 1, 1, 1, 0, 0, 32'h304, E_KEP, 1, 0, 0, 0, 32'h0);   // 35 blocked by stall
    add(0, 0, 0, 1, 0, 0, 32'h308, E_IGN, 0, 0, 0, 0, 32'h0);   // 36 nothing taken

    // Two reset edges so the DUT has a defined state before the table.
    rst = 1'b1;
    repeat (2) @(negedge clock);

    for (int k = 0; k < nv; k++) begin
      @(negedge clock);
      drive(tv[k]);
      #2;
      chk_all(k, tv[k]);
      $display("[TB] step %0d rst=%0b stall=%0b irq=%0b pc=0x%0h -> prectl=%0d ack=%0b flush=%0b svc=%0b spc=0x%0h",
               k, tv[k].rst, tv[k].stall, tv[k].irq, tv[k].pc, pc_prectl, irq_ack, id_flush, in_svc, zz_spc);
    end

    // Reset asserted during the IRQ cycle itself.
    @(negedge clock);
    rst = 0; stall_req = 0; irq_req = 1; irq_en = 1; branch_slot = 0; ret_req = 0; pc_i = 32'h400;
    #2; chk("h_pre_take", 100, {28'd0, pc_prectl}, {28'd0, E_IGN});
    @(negedge clock);
    irq_req = 0; rst = 1;
    #2;
    chk("h_irq_prectl", 101, {28'd0, pc_prectl}, {28'd0, E_IRQ});
    chk("h_irq_spc", 101, zz_spc, 32'h400);
    $display("[TB] hand: take at 0x400 -> prectl=%0d spc=0x%0h", pc_prectl, zz_spc);
    @(negedge clock);
    rst = 0;
    #2;
    chk("h_abort_prectl", 102, {28'd0, pc_prectl}, {28'd0, E_RST});
    chk("h_abort_svc", 102, {31'd0, in_svc}, 32'd0);
    chk("h_abort_spc", 102, zz_spc, 32'd0);
    chk("h_abort_ack", 102, {31'd0, irq_ack}, 32'd0);
    $display("[TB] hand: rst in IRQ -> prectl=%0d svc=%0b spc=0x%0h", pc_prectl, in_svc, zz_spc);

    // Count remaining PC_RST cycles, bounded so a stuck FSM cannot hang.
    rst_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      #2;
      if (pc_prectl != E_RST) break;
      rst_seen++;
    end
    chk("h_rst_len", 103, rst_seen, 32'd4);
    chk("h_run_after_rst", 103, {28'd0, pc_prectl}, {28'd0, E_IGN});
    $display("[TB] hand: reset hold-off %0d further cycles, then prectl=%0d", rst_seen, pc_prectl);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
